// File: rtl/sfifo_wr_arb.sv
// Round-robin write arbiter sharing one sfifo write port among NREQ producers.
// Define SFIFO_WR_ARB_ERR_EN to enable the sticky occupancy-mismatch flag on err.
module sfifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int BURST = 4,
  localparam int IDW  = $clog2(NREQ),
  localparam int OCCW = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    fifo_winc,
  output logic [WIDTH-1:0]        fifo_wdata,
  input  logic                    fifo_wfull,
  input  logic                    fifo_pop,
  output logic                    grant_valid,
  output logic [IDW-1:0]          grant_id,
  output logic [OCCW-1:0]         occ,
  output logic                    err
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic            grant_valid_q, grant_valid_d;
  logic [7:0]      beat_q, beat_d;
  logic [OCCW-1:0] occ_q, occ_d;

  logic [WIDTH-1:0] data_arr [NREQ];
  logic             hold, room, cur_valid, accept, last_beat, rel, pop_eff;
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign hold      = (state_q == HOLD);
  assign room      = (occ_q < OCCW'(DEPTH)) & ~fifo_wfull;
  assign cur_valid = req_valid[grant_id_q];
  assign accept    = hold & cur_valid & room;
  assign last_beat = (beat_q == 8'(BURST - 1));
  assign rel       = hold & (~cur_valid | (accept & last_beat));
  assign pop_eff   = fifo_pop & (occ_q != '0);

  assign req_ready   = (hold & room) ? (NREQ'(1) << grant_id_q) : '0;
  assign fifo_winc   = accept;
  assign fifo_wdata  = hold ? data_arr[grant_id_q] : '0;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign occ         = occ_q;

  // First valid requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_d     = beat_q;
    occ_d      = occ_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = HOLD;
          grant_id_d = pick_idx;
          beat_d     = '0;
        end
      end
      HOLD: begin
        if (accept) beat_d = beat_q + 8'd1;
        if (rel) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : IDW'(grant_id_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept && !pop_eff)      occ_d = occ_q + 1'b1;
    else if (!accept && pop_eff) occ_d = occ_q - 1'b1;
    grant_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      beat_q        <= '0;
      occ_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      beat_q        <= beat_d;
      occ_q         <= occ_d;
    end
  end

`ifdef SFIFO_WR_ARB_ERR_EN
  logic err_q, err_d;

  // A registered wfull may legitimately be seen at DEPTH-1 after a pop, not below.
  always_comb begin
    err_d = err_q | (fifo_pop & (occ_q == '0))
                  | (fifo_wfull & (occ_q < OCCW'(DEPTH - 1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Self-checking bench for sfifo_wr_arb: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based model of the arbitration rules.
module tb_sfifo_wr_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int BURST = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_winc;
  logic [WIDTH-1:0]      fifo_wdata;
  logic                  fifo_wfull;
  logic                  fifo_pop;
  logic                  grant_valid;
  logic [1:0]            grant_id;
  logic [4:0]            occ;
  logic                  err;

  sfifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata),
    .fifo_wfull(fifo_wfull), .fifo_pop(fifo_pop), .grant_valid(grant_valid),
    .grant_id(grant_id), .occ(occ), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: grant holder, rotation pointer, beats in current grant,
  // and the FIFO contents as a queue (occupancy is its size).
  bit               m_hold;
  int               m_ptr, m_gid, m_beats;
  logic [WIDTH-1:0] m_q[$];
  bit               m_err;
  bit               wf_inject;
  logic             last_winc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_ptr = 0; m_gid = 0; m_beats = 0; m_err = 0;
    m_q.delete();
  endtask

  // One clock cycle: settle, compare against the model, clock, advance model.
  task automatic step();
    bit               room, e_winc, popok, found;
    logic [NREQ-1:0]  e_ready;
    logic [WIDTH-1:0] e_data;
    int               idx;
    fifo_wfull = (m_q.size() == DEPTH) | wf_inject;
    #1;
    room    = (m_q.size() < DEPTH) && !fifo_wfull;
    e_ready = (m_hold && room) ? NREQ'(1 << m_gid) : '0;
    e_winc  = m_hold && req_valid[m_gid] && room;
    e_data  = req_data[m_gid*WIDTH +: WIDTH];
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("fifo_winc", 32'(fifo_winc), 32'(e_winc));
    if (e_winc) chk("fifo_wdata", 32'(fifo_wdata), 32'(e_data));
    chk("grant_valid", 32'(grant_valid), 32'(m_hold));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("occ", 32'(occ), 32'(m_q.size()));
    chk("err", 32'(err), 32'(m_err));
    last_winc = fifo_winc;
    @(posedge clk);
`ifdef SFIFO_WR_ARB_ERR_EN
    if ((fifo_pop && m_q.size() == 0) || (fifo_wfull && m_q.size() < DEPTH - 1)) m_err = 1;
`endif
    popok = fifo_pop && (m_q.size() > 0);
    if (popok) void'(m_q.pop_front());
    if (e_winc) m_q.push_back(e_data);
    if (!m_hold) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found = 1; m_gid = idx;
        end
      end
      if (found) begin m_hold = 1; m_beats = 0; end
    end else begin
      if (e_winc) m_beats++;
      if ((e_winc && m_beats == BURST) || !req_valid[m_gid]) begin
        m_hold = 0;
        m_ptr  = (m_gid + 1) % NREQ;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; fifo_pop = 0; wf_inject = 0; fifo_wfull = 0;
    req_data = NREQ*WIDTH'($urandom);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_grant_valid", 32'(grant_valid), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_winc", 32'(fifo_winc), 0);
    chk("rst_wdata", 32'(fifo_wdata), 0);
    chk("rst_err", 32'(err), 0);
    rst = 0;
  endtask

  initial begin
    int gseq[$];
    int bcnt[$];
    bit prev_gv;
    int guard;

    // Single requester burst until the FIFO is full.
    do_reset();
    req_valid = 4'b0010;
    for (int c = 0; c < 24; c++) begin
      req_data = NREQ*WIDTH'($urandom);
      step();
      if (c == 0) begin
        chk("single_first_grant_valid", 32'(grant_valid), 1);
        chk("single_first_grant_id", 32'(grant_id), 1);
      end
    end
    chk("single_full_occ", 32'(occ), 16);
    chk("single_full_ready", 32'(req_ready), 0);
    chk("single_full_holding", 32'(grant_valid), 1);

    // Round robin with all requesters valid and a reader draining.
    do_reset();
    req_valid = 4'b1111;
    prev_gv = 0;
    for (int c = 0; c < 30; c++) begin
      req_data = NREQ*WIDTH'($urandom);
      fifo_pop = (m_q.size() > 0);
      step();
      if (last_winc && gseq.size() > 0) bcnt[bcnt.size()-1]++;
      if (grant_valid && !prev_gv) begin
        gseq.push_back(int'(grant_id));
        bcnt.push_back(0);
      end
      prev_gv = grant_valid;
    end
    chk("rr_grant_count", 32'(gseq.size() >= 5), 1);
    for (int i = 0; i < 5 && i < gseq.size(); i++) chk("rr_order", 32'(gseq[i]), 32'(i % 4));
    for (int i = 0; i < 4 && i < bcnt.size(); i++) chk("rr_beats", 32'(bcnt[i]), 4);
    fifo_pop = 0;

    // Early release: requester 2 drops valid after two beats.
    do_reset();
    req_valid = 4'b0100;
    repeat (3) step();
    req_valid = 4'b1001;
    step();
    chk("early_release", 32'(grant_valid), 0);
    step();
    chk("early_next_grant_valid", 32'(grant_valid), 1);
    chk("early_next_grant_id", 32'(grant_id), 3);

    // Full boundary: prefill to 15, then a beat with and without a pop.
    do_reset();
    guard = 0;
    while (!(m_q.size() == 15 && !m_hold) && guard < 100) begin
      req_valid = (m_q.size() < 15) ? 4'b0001 : 4'b0000;
      step();
      guard++;
    end
    chk("prefill_done", 32'(guard < 100), 1);
    req_valid = 4'b0001;
    step();
    fifo_pop = 1;
    step();
    chk("full_pop_winc", 32'(last_winc), 1);
    chk("full_pop_occ", 32'(occ), 15);
    fifo_pop = 0;
    step();
    chk("full_nopop_occ", 32'(occ), 16);
    step();
    chk("full_stall_winc", 32'(last_winc), 0);
    fifo_pop = 1;
    step();
    fifo_pop = 0;
    step();
    chk("full_after_pop_winc", 32'(last_winc), 1);

    // Mid-burst reset of requester 3.
    do_reset();
    req_valid = 4'b1000;
    repeat (3) step();
    chk("mid_occ_before", 32'(occ), 2);
    rst = 1;
    #1;
    chk("mid_rst_grant_valid", 32'(grant_valid), 0);
    chk("mid_rst_occ", 32'(occ), 0);
    chk("mid_rst_winc", 32'(fifo_winc), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("mid_rst_held_winc", 32'(fifo_winc), 0);
    rst = 0;
    req_valid = 4'b1111;
    step();
    chk("mid_after_grant_id", 32'(grant_id), 0);
    chk("mid_after_grant_valid", 32'(grant_valid), 1);

    // Pop at empty: ignored for occupancy, flagged when the error check exists.
    do_reset();
    fifo_pop = 1;
    step();
    fifo_pop = 0;
    chk("pop_empty_occ", 32'(occ), 0);
`ifdef SFIFO_WR_ARB_ERR_EN
    chk("err_set", 32'(err), 1);
    step();
    chk("err_held", 32'(err), 1);
`else
    chk("err_tied", 32'(err), 0);
`endif

    // Random traffic, including spurious wfull and pops at empty.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NREQ; r++)
        if ($urandom_range(0, 3) == 0) req_valid[r] = ~req_valid[r];
      req_data  = {$urandom, $urandom};
      fifo_pop  = ($urandom_range(0, 2) == 0);
      wf_inject = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
